// File: rtl/ddu_run_ctrl.sv
// Run/debug gate for the multi-cycle CPU: continuous run, single-step, address
// breakpoints and a DDU address browser, plus a retired-fetch counter.
module ddu_run_ctrl #(
  parameter int ADDR_W      = 32,
  parameter int NUM_BP      = 4,
  parameter int ADDR_STEP   = 4,
  parameter int FETCH_STATE = 0,
  parameter int STATE_W     = 4,
  parameter int CNT_W       = 32,
  localparam int BPI_W      = (NUM_BP > 1) ? $clog2(NUM_BP) : 1
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     cont_i,
  input  logic                     step_i,
  input  logic                     inc_i,
  input  logic                     dec_i,
  input  logic [ADDR_W-1:0]        pc_i,
  input  logic [STATE_W-1:0]       cpu_state_i,
  input  logic [NUM_BP*ADDR_W-1:0] bp_addr_i,
  input  logic [NUM_BP-1:0]        bp_en_i,
  output logic                     run_o,
  output logic [ADDR_W-1:0]        ddu_addr_o,
  output logic                     halted_o,
  output logic                     bp_hit_o,
  output logic [BPI_W-1:0]         bp_idx_o,
  output logic [CNT_W-1:0]         instr_cnt_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_STEP = 2'd2;
  localparam logic [1:0] S_HOLD = 2'd3;

  logic [1:0]        state_q, state_d;
  logic              step_q, inc_q, dec_q;
  logic              resume_q, resume_d;
  logic              first_q, first_d;
  logic              bp_hit_q, bp_hit_d;
  logic [BPI_W-1:0]  bp_idx_q, bp_idx_d;
  logic [ADDR_W-1:0] ddu_addr_q, ddu_addr_d;
  logic [CNT_W-1:0]  instr_cnt_q, instr_cnt_d;

  logic             step_p, inc_p, dec_p;
  logic             at_fetch, match, bp_stop, run;
  logic [BPI_W-1:0] match_idx;

  assign step_p   = step_i & ~step_q;
  assign inc_p    = inc_i & ~inc_q;
  assign dec_p    = dec_i & ~dec_q;
  assign at_fetch = (cpu_state_i == STATE_W'(FETCH_STATE));

  // Scan high-to-low so the lowest matching comparator is the one left standing.
  always_comb begin
    match     = 1'b0;
    match_idx = '0;
    for (int i = NUM_BP - 1; i >= 0; i--) begin
      if (bp_en_i[i] && (pc_i == bp_addr_i[i*ADDR_W +: ADDR_W])) begin
        match     = 1'b1;
        match_idx = BPI_W'(i);
      end
    end
  end

  // resume masks the breakpoint for the one fetch at the PC we stopped on.
  assign bp_stop = at_fetch & match & ~resume_q;

  always_comb begin
    run = 1'b0;
    case (state_q)
      S_RUN:   run = cont_i & ~bp_stop;
      S_STEP:  run = first_q | ~at_fetch;
      default: run = 1'b0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    first_d  = first_q;
    bp_hit_d = bp_hit_q;
    bp_idx_d = bp_idx_q;
    resume_d = resume_q;
    if (run && at_fetch) resume_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cont_i) begin
          state_d  = S_RUN;
          resume_d = 1'b1;
          bp_hit_d = 1'b0;
        end else if (step_p) begin
          state_d  = S_STEP;
          first_d  = 1'b1;
          bp_hit_d = 1'b0;
        end
      end
      S_RUN: begin
        if (!cont_i) begin
          state_d = S_IDLE;
        end else if (bp_stop) begin
          state_d  = S_HOLD;
          bp_hit_d = 1'b1;
          bp_idx_d = match_idx;
        end
      end
      S_STEP: begin
        first_d = 1'b0;
        if (!first_q && at_fetch) state_d = cont_i ? S_HOLD : S_IDLE;
      end
      S_HOLD: begin
        if (!cont_i) begin
          state_d = S_IDLE;
        end else if (step_p) begin
          state_d  = S_STEP;
          first_d  = 1'b1;
          bp_hit_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ddu_addr_d = ddu_addr_q;
    case ({inc_p, dec_p})
      2'b10:   ddu_addr_d = ddu_addr_q + ADDR_W'(ADDR_STEP);
      2'b01:   ddu_addr_d = ddu_addr_q - ADDR_W'(ADDR_STEP);
      default: ddu_addr_d = ddu_addr_q;
    endcase
  end

  always_comb begin
    instr_cnt_d = instr_cnt_q;
    if (run && at_fetch) instr_cnt_d = instr_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= S_IDLE;
      step_q      <= 1'b0;
      inc_q       <= 1'b0;
      dec_q       <= 1'b0;
      resume_q    <= 1'b0;
      first_q     <= 1'b0;
      bp_hit_q    <= 1'b0;
      bp_idx_q    <= '0;
      ddu_addr_q  <= '0;
      instr_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      step_q      <= step_i;
      inc_q       <= inc_i;
      dec_q       <= dec_i;
      resume_q    <= resume_d;
      first_q     <= first_d;
      bp_hit_q    <= bp_hit_d;
      bp_idx_q    <= bp_idx_d;
      ddu_addr_q  <= ddu_addr_d;
      instr_cnt_q <= instr_cnt_d;
    end
  end

  assign run_o       = run;
  assign ddu_addr_o  = ddu_addr_q;
  assign halted_o    = (state_q == S_IDLE) || (state_q == S_HOLD);
  assign bp_hit_o    = bp_hit_q;
  assign bp_idx_o    = bp_idx_q;
  assign instr_cnt_o = instr_cnt_q;

endmodule

// File: doc/ddu_run_ctrl.md
Name: ddu_run_ctrl

Overview:
Parametrised run/debug controller between the front-panel inputs and the multi-cycle MIPS CPU run gate.
- Replaces the bare `run` level with four modes: continuous run, single-instruction step, N address breakpoints, and a DDU address browser with increment/decrement.
- Counts retired instruction fetches.
- Sits beside the CPU top. Its `run` drives the CPU's existing run input; `ddu_addr` drives `DDU_addr`.

Parameters:
ADDR_W, 32, width of pc, breakpoint addresses and ddu_addr
NUM_BP, 4, number of breakpoint comparators
ADDR_STEP, 4, ddu_addr increment/decrement amount
FETCH_STATE, 0, CPU state encoding for instruction fetch
STATE_W, 4, width of CPU state input
CNT_W, 32, instruction counter width

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset, asynchronous, active-low (0 = reset)
cont  in  1  level: continuous-run request
step  in  1  level button; rising edge requests one instruction
inc  in  1  level button; rising edge adds ADDR_STEP to ddu_addr
dec  in  1  level button; rising edge subtracts ADDR_STEP from ddu_addr
pc  in  ADDR_W  CPU current PC (registered in CPU)
cpu_state  in  STATE_W  CPU FSM state (registered in CPU)
bp_addr  in  NUM_BP*ADDR_W  breakpoint addresses, entry i at [i*ADDR_W +: ADDR_W]
bp_en  in  NUM_BP  per-breakpoint enable
run  out  1  CPU clock-enable, combinational
ddu_addr  out  ADDR_W  debug display address
halted  out  1  1 when FSM is in IDLE or HOLD
bp_hit  out  1  halted by breakpoint
bp_idx  out  clog2(NUM_BP) (min 1)  lowest matching breakpoint index
instr_cnt  out  CNT_W  count of executed fetch cycles

Behaviour:
Reset values:
- FSM = IDLE.
- ddu_addr, instr_cnt, bp_idx, bp_hit, resume, first = 0.
- halted = 1, run = 0.

Edge detection and fetch:
- step, inc and dec are each registered once. pulse = in & ~in_q.
- at_fetch = (cpu_state == FETCH_STATE).
- match = any i with bp_en[i] and pc == bp_addr[i]. Lowest i wins.

run (combinational; no loop because pc and cpu_state are CPU registers):
- RUN: cont & ~(at_fetch & match & ~resume).
- STEP: first | ~at_fetch.
- IDLE/HOLD: 0.

FSM transitions:
- IDLE:
  - cont=1 → RUN, resume=1, bp_hit=0.
  - else step pulse → STEP, first=1, bp_hit=0.
- RUN:
  - cont=0 → IDLE.
  - else at_fetch & match & ~resume → HOLD, bp_hit=1, bp_idx latched. run=0 that cycle, so the breakpoint instruction is not fetched.
- STEP:
  - first cleared after the first cycle.
  - When ~first & at_fetch → HOLD if cont=1, else IDLE.
  - Breakpoints are ignored in STEP. cont changes are ignored until the step ends.
- HOLD:
  - cont=0 → IDLE; bp_hit kept.
  - step pulse → STEP, first=1, bp_hit=0.
  - cont remaining 1 stays in HOLD. Re-running requires cont 0 then 1.

resume flag:
- Cleared on the first cycle with run=1 & at_fetch.
- Lets execution resume past the breakpoint PC.

Other counters and outputs:
- instr_cnt += 1 on every cycle with run=1 & at_fetch. Wraps mod 2^CNT_W.
- ddu_addr: inc pulse alone → +ADDR_STEP; dec pulse alone → −ADDR_STEP; both or neither → hold. Wraps mod 2^ADDR_W.
- ddu_addr updates in all FSM states.
- A step pulse during RUN or STEP is ignored (not queued).
- Reset mid-operation: everything returns to reset values immediately and asynchronously; run drops to 0 the same instant.

Test Plan:
- Reset with cont=1 held → run=0 and halted=1 during reset. First cycle after release: FSM=RUN, then run=1 continuously; instr_cnt increments once per fetch.
- Stub CPU cycles through states 0,1,2,3 with pc +4 per instruction; cont=0; one step pulse → run high exactly 4 cycles; instr_cnt 0→1; FSM ends in IDLE with pc=4.
- bp_addr[2]=0x0C, bp_en=4'b0100, cont=1 → halt with pc=0x0C at fetch, run=0 there; bp_hit=1, bp_idx=2, instr_cnt=3. Toggle cont 0→1 → fetch of 0x0C proceeds; no re-halt at 0x0C.
- Breakpoints at indices 1 and 3, both = 0x08 → bp_idx=1. Step pulse in HOLD with cont=1 → one instruction, back to HOLD, bp_hit=0.
- ddu_addr=0, dec pulse → 0xFFFFFFFC; inc and dec pulses in the same cycle → unchanged; 3 inc pulses → 0x00000008.
- Assert rst=0 mid-STEP (cycle 2) → run=0 immediately, FSM=IDLE, instr_cnt=0, ddu_addr=0.
